read_fmps_link: RTL and testbench
=================================

Name: read_fmps_link

Overview:
- Synthesizable receive stage for the FMPS test link. Sits directly downstream of the FMPS test-link writer, on the Aurora user-clock side.
- Consumes the AXI-Stream packet stream and checks header magic, index and length.
- Delivers the decoded index and data word(s) as strobed outputs.
- Builds a per-FA-cycle bitmap of the packet indices received, for link-health CSRs.

Parameters:
- MAGIC_WIDTH, 16, header magic field width.
- MAGIC_START_BIT, 16, LSB position of magic in header word.
- INDEX_WIDTH, 5, packet index field width; bitmap width is 2**INDEX_WIDTH.
- INDEX_START_BIT, 10, LSB position of index in header word.
- NUM_DATA_WORDS, 1, number of 32-bit data words following the header.
- EXPECTED_MAGIC, 16'hB6CF, required header magic.
- ERR_CNT_WIDTH, 16, width of the saturating error counter.

Ports:
- auroraUserClk  in  1  sole clock.
- auroraResetN  in  1  asynchronous active-low reset.
- auroraChannelUp  in  1  link up; low forces resync.
- auroraFAstrobe  in  1  one-cycle FA cycle boundary.
- TDATA  in  32  stream data.
- TVALID  in  1  stream valid.
- TLAST  in  1  last word of packet.
- TREADY  out  1  stream ready.
- packetStrobe  out  1  one-cycle pulse when a packet has been decoded.
- packetIndex  out  INDEX_WIDTH  index of the decoded packet.
- packetData  out  32*NUM_DATA_WORDS  data words of the packet; word 0 in bits [31:0].
- statusStrobe  out  1  one-cycle pulse per packet end, good or bad.
- statusCode  out  2  0=OK, 1=BAD_MAGIC, 2=BAD_LENGTH, 3=DUPLICATE.
- cycleStrobe  out  1  one-cycle pulse; cycleMap and cyclePacketCount are valid.
- cycleMap  out  2**INDEX_WIDTH  indices received in the closed FA cycle.
- cyclePacketCount  out  INDEX_WIDTH+1  good packets in the closed FA cycle; saturating.
- errorCount  out  ERR_CNT_WIDTH  saturating count of non-OK status events.

Behaviour:
- Reset: all outputs, maps and counters are 0; FSM is in HEADER; TREADY is 0.
- TREADY equals auroraChannelUp, registered: it is 1 from the cycle after channel up.
- A word is accepted when TVALID && TREADY.
- FSM state HEADER, on an accepted word:
  - magic mismatch: emit BAD_MAGIC; go to DISCARD, or stay in HEADER if TLAST is set.
  - TLAST set with a good magic: emit BAD_LENGTH; stay in HEADER.
  - otherwise: latch the index, clear the word counter, go to DATA.
- FSM state DATA, on an accepted word:
  - store the word at slot wordCnt.
  - TLAST with wordCnt == NUM_DATA_WORDS-1: the packet completes; go to HEADER.
  - TLAST with wordCnt < NUM_DATA_WORDS-1: emit BAD_LENGTH; go to HEADER.
  - no TLAST with wordCnt == NUM_DATA_WORDS-1: emit BAD_LENGTH; go to DISCARD.
- FSM state DISCARD: drop accepted words until one with TLAST, then go to HEADER. No further status is emitted for the discarded words.
- Packet completion:
  - packetStrobe and statusStrobe assert on the cycle after the last word is accepted. Latency is 1.
  - packetIndex and packetData hold their values until the next completion.
  - statusCode is DUPLICATE if the index bit is already set in the current-cycle map, otherwise OK.
  - On DUPLICATE, packetStrobe still pulses and the data is delivered.
  - On OK, the index bit is set in the map and the packet counter increments.
- Errors: BAD_MAGIC and BAD_LENGTH pulse statusStrobe only. Every non-OK code increments errorCount, which saturates at all-ones.
- auroraFAstrobe closes the cycle:
  - cycleMap and cyclePacketCount are loaded from the running map and counter; cycleStrobe asserts on the next cycle.
  - The running map and counter clear.
  - A packet completing on the same edge counts in the closing cycle.
  - An FA strobe arriving mid-packet does not disturb the FSM.
- auroraChannelUp low:
  - FSM goes to HEADER immediately and any partial packet is dropped with no status.
  - The running map and counter clear.
  - errorCount and the cycle outputs are held.

Decomposition:
- Package fmps_link_pkg holds:
  - the status code constants (OK, BAD_MAGIC, BAD_LENGTH, DUPLICATE);
  - the default magic 16'hB6CF;
  - the header field position constants.
- One natural sub-module, fmps_cycle_tracker: running map, packet counter, FA-boundary latching and cycleStrobe. The FSM and word assembly stay in the top level.

Test Plan:
- Good packets: channel up, header 0xB6CF_0000|(3<<10), data 0x12345678 with TLAST -> 1 cycle later packetStrobe=1, packetIndex=3, packetData=0x12345678, statusCode=0.
- Full FA cycle: 8 good packets with indices 0..7, then auroraFAstrobe -> next cycle cycleStrobe=1, cycleMap=0x000000FF, cyclePacketCount=8; the next cycle's map starts at 0.
- Bad magic: header 0xDEAD_0000 followed by 1 word with TLAST -> single statusStrobe with statusCode=1, no packetStrobe, errorCount=1; the following good packet decodes normally.
- Length errors: header with TLAST -> code 2. Header + 2 data words, TLAST on the 2nd (NUM_DATA_WORDS=1) -> code 2 after the 1st data word, 2nd word discarded. errorCount=2 after both.
- Duplicate index: index 5 sent twice in one FA cycle -> second packet gives packetStrobe=1, statusCode=3; cyclePacketCount=1; cycleMap bit 5 set.
- Resync and reset: channel dropped after the header, then restored with a fresh packet -> no status for the partial packet, fresh packet OK. Asserting auroraResetN mid-packet -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/fmps_link_pkg.sv
// fmps_link_pkg: shared status codes, header layout defaults and FSM states for the FMPS link receiver
package fmps_link_pkg;
  localparam logic [1:0] ST_OK = 2'd0, ST_BAD_MAGIC = 2'd1, ST_BAD_LENGTH = 2'd2, ST_DUPLICATE = 2'd3;
  localparam logic [15:0] DEFAULT_MAGIC = 16'hB6CF;
  localparam int DEF_MAGIC_WIDTH = 16, DEF_MAGIC_START_BIT = 16, DEF_INDEX_WIDTH = 5, DEF_INDEX_START_BIT = 10;
  typedef enum logic [1:0] {S_HEADER, S_DATA, S_DISCARD} state_t;
endpackage

// File: rtl/fmps_cycle_tracker.sv
// fmps_cycle_tracker: running index map and good-packet count, snapshotted at each FA boundary
module fmps_cycle_tracker #(
  parameter int INDEX_WIDTH = 5
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clear,
  input  logic                        good,
  input  logic [INDEX_WIDTH-1:0]      index,
  input  logic                        fa,
  output logic [2**INDEX_WIDTH-1:0]   map,
  output logic                        cycle_strobe,
  output logic [2**INDEX_WIDTH-1:0]   cycle_map,
  output logic [INDEX_WIDTH:0]        cycle_count
);
  localparam int MAP = 2**INDEX_WIDTH;
  logic [MAP-1:0] map_next;
  logic [INDEX_WIDTH:0] cnt, cnt_next;
  always_comb begin
    map_next = good ? map | (MAP'(1) << index) : map;
    cnt_next = good && cnt != '1 ? cnt + 1'b1 : cnt;
  end
  // a packet completing on the boundary edge belongs to the closing cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      map <= '0;
      cnt <= '0;
      cycle_strobe <= 1'b0;
      cycle_map <= '0;
      cycle_count <= '0;
    end else begin
      cycle_strobe <= fa && !clear;
      if (clear) begin
        map <= '0;
        cnt <= '0;
      end else if (fa) begin
        cycle_map <= map_next;
        cycle_count <= cnt_next;
        map <= '0;
        cnt <= '0;
      end else begin
        map <= map_next;
        cnt <= cnt_next;
      end
    end
endmodule

// File: rtl/read_fmps_link.sv
// read_fmps_link: FMPS test-link receive stage; checks header magic/length, delivers packets, tracks per-FA-cycle indices
module read_fmps_link
  import fmps_link_pkg::*;
#(
  parameter int MAGIC_WIDTH = DEF_MAGIC_WIDTH,
  parameter int MAGIC_START_BIT = DEF_MAGIC_START_BIT,
  parameter int INDEX_WIDTH = DEF_INDEX_WIDTH,
  parameter int INDEX_START_BIT = DEF_INDEX_START_BIT,
  parameter int NUM_DATA_WORDS = 1,
  parameter logic [MAGIC_WIDTH-1:0] EXPECTED_MAGIC = DEFAULT_MAGIC,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                          auroraUserClk,
  input  logic                          auroraResetN,
  input  logic                          auroraChannelUp,
  input  logic                          auroraFAstrobe,
  input  logic [31:0]                   TDATA,
  input  logic                          TVALID,
  input  logic                          TLAST,
  output logic                          TREADY,
  output logic                          packetStrobe,
  output logic [INDEX_WIDTH-1:0]        packetIndex,
  output logic [32*NUM_DATA_WORDS-1:0]  packetData,
  output logic                          statusStrobe,
  output logic [1:0]                    statusCode,
  output logic                          cycleStrobe,
  output logic [2**INDEX_WIDTH-1:0]     cycleMap,
  output logic [INDEX_WIDTH:0]          cyclePacketCount,
  output logic [ERR_CNT_WIDTH-1:0]      errorCount
);
  localparam int WCW = NUM_DATA_WORDS > 1 ? $clog2(NUM_DATA_WORDS) : 1;
  localparam logic [WCW-1:0] LAST_SLOT = WCW'(NUM_DATA_WORDS - 1);
  state_t state;
  logic [WCW-1:0] wc;
  logic [INDEX_WIDTH-1:0] idx;
  logic [32*NUM_DATA_WORDS-1:0] words, words_next;
  logic [2**INDEX_WIDTH-1:0] map;
  logic acc, magic_ok, last_slot, complete, dup, fire;
  logic [1:0] code;
  always_comb begin
    acc = TVALID && TREADY && auroraChannelUp;
    magic_ok = TDATA[MAGIC_START_BIT +: MAGIC_WIDTH] == EXPECTED_MAGIC;
    last_slot = wc == LAST_SLOT;
    complete = acc && state == S_DATA && TLAST && last_slot;
    dup = map[idx];
    fire = acc && (state == S_HEADER ? !magic_ok || TLAST : state == S_DATA && (TLAST || last_slot));
    code = state == S_HEADER ? (magic_ok ? ST_BAD_LENGTH : ST_BAD_MAGIC) : !complete ? ST_BAD_LENGTH : dup ? ST_DUPLICATE : ST_OK;
    words_next = words;
    words_next[32*int'(wc) +: 32] = TDATA;
  end
  // channel loss drops any partial packet silently; counters and cycle outputs survive
  always_ff @(posedge auroraUserClk or negedge auroraResetN)
    if (!auroraResetN) begin
      state <= S_HEADER;
      wc <= '0;
      idx <= '0;
      words <= '0;
      TREADY <= 1'b0;
      packetStrobe <= 1'b0;
      packetIndex <= '0;
      packetData <= '0;
      statusStrobe <= 1'b0;
      statusCode <= ST_OK;
      errorCount <= '0;
    end else begin
      TREADY <= auroraChannelUp;
      packetStrobe <= complete;
      statusStrobe <= fire;
      if (fire) statusCode <= code;
      if (complete) begin
        packetIndex <= idx;
        packetData <= words_next;
      end
      if (fire && code != ST_OK && errorCount != '1) errorCount <= errorCount + 1'b1;
      if (!auroraChannelUp) state <= S_HEADER;
      else if (acc)
        case (state)
          S_HEADER: begin
            state <= TLAST ? S_HEADER : magic_ok ? S_DATA : S_DISCARD;
            idx <= TDATA[INDEX_START_BIT +: INDEX_WIDTH];
            wc <= '0;
          end
          S_DATA: begin
            words <= words_next;
            wc <= wc + 1'b1;
            state <= TLAST ? S_HEADER : last_slot ? S_DISCARD : S_DATA;
          end
          default: state <= TLAST ? S_HEADER : S_DISCARD;
        endcase
    end
  fmps_cycle_tracker #(.INDEX_WIDTH(INDEX_WIDTH)) u_tracker (
    .clk(auroraUserClk),
    .rst_n(auroraResetN),
    .clear(!auroraChannelUp),
    .good(complete && !dup),
    .index(idx),
    .fa(auroraFAstrobe),
    .map(map),
    .cycle_strobe(cycleStrobe),
    .cycle_map(cycleMap),
    .cycle_count(cyclePacketCount)
  );
endmodule

// File: tb/tb_read_fmps_link.sv
// tb_read_fmps_link: directed vector table plus randomized packets checked against a packet-level model
module tb_read_fmps_link;
  logic clk = 0, rst_n = 0, up = 0, fa = 0, tvalid = 0, tlast = 0;
  logic [31:0] tdata = 0;
  logic TREADY, packetStrobe, statusStrobe, cycleStrobe;
  logic [4:0] packetIndex;
  logic [31:0] packetData, cycleMap;
  logic [1:0] statusCode;
  logic [5:0] cyclePacketCount;
  logic [15:0] errorCount;
  int total = 0, bad = 0;
  bit mon_en = 0;

  read_fmps_link dut (
    .auroraUserClk(clk), .auroraResetN(rst_n), .auroraChannelUp(up), .auroraFAstrobe(fa),
    .TDATA(tdata), .TVALID(tvalid), .TLAST(tlast), .TREADY(TREADY),
    .packetStrobe(packetStrobe), .packetIndex(packetIndex), .packetData(packetData),
    .statusStrobe(statusStrobe), .statusCode(statusCode), .cycleStrobe(cycleStrobe),
    .cycleMap(cycleMap), .cyclePacketCount(cyclePacketCount), .errorCount(errorCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic v, l, f;
    logic [31:0] d;
    logic ps, ss;
    logic [1:0] sc;
    logic [4:0] pi;
    logic [31:0] pd;
    logic [15:0] ec;
    logic cs;
    logic [31:0] cm;
    logic [5:0] cc;
  } vec_t;
  typedef struct { logic [1:0] code; logic [4:0] idx; logic [31:0] data; logic [15:0] ec; } st_t;
  typedef struct { logic [31:0] map; logic [5:0] cnt; } cyc_t;

  vec_t tbl[$];
  st_t sq[$];
  cyc_t cq[$];
  st_t s;
  cyc_t c;
  logic [31:0] pk[$];
  bit seen[32];
  int cnt_m, err_m;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask

  function automatic logic [31:0] h(input int i);
    return {16'hB6CF, 1'b0, i[4:0], 10'd0};
  endfunction

  function automatic vec_t mk(input logic v, l, f, input logic [31:0] d, input logic ps, ss, input logic [1:0] sc,
                              input logic [4:0] pi, input logic [31:0] pd, input logic [15:0] ec,
                              input logic cs, input logic [31:0] cm, input logic [5:0] cc);
    vec_t r;
    r.v = v; r.l = l; r.f = f; r.d = d; r.ps = ps; r.ss = ss; r.sc = sc; r.pi = pi; r.pd = pd;
    r.ec = ec; r.cs = cs; r.cm = cm; r.cc = cc;
    return r;
  endfunction

  task automatic drive(input logic v, input logic l, input logic [31:0] d, input logic f);
    tvalid = v; tlast = l; tdata = d; fa = f;
    @(posedge clk);
    #1;
    tvalid = 0; tlast = 0; tdata = 0; fa = 0;
  endtask

  task automatic step();
    drive(0, 0, 0, 0);
  endtask

  task automatic send_pkt();
    foreach (pk[j]) begin
      if ($urandom_range(0, 3) == 0) step();
      drive(1, j == pk.size() - 1, pk[j], 0);
    end
  endtask

  function automatic logic all_out();
    return |{TREADY, packetStrobe, packetIndex, packetData, statusStrobe, statusCode,
             cycleStrobe, cycleMap, cyclePacketCount, errorCount};
  endfunction

  always @(negedge clk)
    if (mon_en) begin
      if (statusStrobe) begin
        chk("status_expected", sq.size() != 0, 1);
        if (sq.size() != 0) begin
          s = sq.pop_front();
          chk("rnd_code", statusCode, s.code);
          chk("rnd_err", errorCount, s.ec);
          chk("rnd_pstrobe", packetStrobe, s.code == 0 || s.code == 3);
          if (s.code == 0 || s.code == 3) begin
            chk("rnd_idx", packetIndex, s.idx);
            chk("rnd_data", packetData, s.data);
          end
        end
      end else chk("rnd_orphan_packet", packetStrobe, 0);
      if (cycleStrobe) begin
        chk("cycle_expected", cq.size() != 0, 1);
        if (cq.size() != 0) begin
          c = cq.pop_front();
          chk("rnd_cmap", cycleMap, c.map);
          chk("rnd_ccount", cyclePacketCount, c.cnt);
        end
      end
    end

  initial begin
    int k, len, ix;
    logic [31:0] hdr, m;
    tbl.push_back(mk(1,0,0,h(3),         0,0,0,0,0,             0, 0,0,0));
    tbl.push_back(mk(1,1,0,32'h12345678, 1,1,0,3,32'h12345678,  0, 0,0,0));
    tbl.push_back(mk(1,0,0,32'hDEAD0000, 0,1,1,0,0,             1, 0,0,0));
    tbl.push_back(mk(1,1,0,32'h0BAD0BAD, 0,0,0,0,0,             1, 0,0,0));
    tbl.push_back(mk(1,1,0,h(5),         0,1,2,0,0,             2, 0,0,0));
    tbl.push_back(mk(1,0,0,h(6),         0,0,0,0,0,             2, 0,0,0));
    tbl.push_back(mk(1,0,0,32'hAAAAAAAA, 0,1,2,0,0,             3, 0,0,0));
    tbl.push_back(mk(1,1,0,32'hBBBBBBBB, 0,0,0,0,0,             3, 0,0,0));
    tbl.push_back(mk(1,0,0,h(5),         0,0,0,0,0,             3, 0,0,0));
    tbl.push_back(mk(1,1,0,32'h55,       1,1,0,5,32'h55,        3, 0,0,0));
    tbl.push_back(mk(1,0,0,h(5),         0,0,0,0,0,             3, 0,0,0));
    tbl.push_back(mk(1,1,0,32'h66,       1,1,3,5,32'h66,        4, 0,0,0));
    tbl.push_back(mk(0,0,1,0,            0,0,0,0,0,             4, 1,32'h28,2));
    tbl.push_back(mk(1,0,0,h(9),         0,0,0,0,0,             4, 0,0,0));
    tbl.push_back(mk(1,1,1,32'h99,       1,1,0,9,32'h99,        4, 1,32'h200,1));
    tbl.push_back(mk(1,0,0,h(4),         0,0,0,0,0,             4, 0,0,0));
    tbl.push_back(mk(0,0,1,0,            0,0,0,0,0,             4, 1,0,0));
    tbl.push_back(mk(1,1,0,32'h44,       1,1,0,4,32'h44,        4, 0,0,0));
    tbl.push_back(mk(0,0,1,0,            0,0,0,0,0,             4, 1,32'h10,1));

    repeat (2) @(posedge clk);
    #1;
    chk("reset_all_zero", all_out(), 0);
    rst_n = 1;
    step();
    chk("tready_down", TREADY, 0);
    up = 1;
    chk("tready_lag", TREADY, 0);
    step();
    chk("tready_up", TREADY, 1);

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].l, tbl[i].d, tbl[i].f);
      chk($sformatf("v%0d_pstrobe", i), packetStrobe, tbl[i].ps);
      chk($sformatf("v%0d_sstrobe", i), statusStrobe, tbl[i].ss);
      chk($sformatf("v%0d_errcnt", i), errorCount, tbl[i].ec);
      chk($sformatf("v%0d_cstrobe", i), cycleStrobe, tbl[i].cs);
      if (tbl[i].ss) chk($sformatf("v%0d_code", i), statusCode, tbl[i].sc);
      if (tbl[i].ps) begin
        chk($sformatf("v%0d_idx", i), packetIndex, tbl[i].pi);
        chk($sformatf("v%0d_data", i), packetData, tbl[i].pd);
      end
      if (tbl[i].cs) begin
        chk($sformatf("v%0d_cmap", i), cycleMap, tbl[i].cm);
        chk($sformatf("v%0d_ccount", i), cyclePacketCount, tbl[i].cc);
      end
    end

    for (int i = 0; i < 8; i++) begin
      drive(1, 0, h(i), 0);
      drive(1, 1, 32'hC0DE0000 + i, 0);
      chk("full_pstrobe", packetStrobe, 1);
      chk("full_idx", packetIndex, i[4:0]);
      chk("full_code", statusCode, 0);
    end
    drive(0, 0, 0, 1);
    chk("full_cstrobe", cycleStrobe, 1);
    chk("full_cmap", cycleMap, 32'hFF);
    chk("full_ccount", cyclePacketCount, 8);
    drive(1, 0, h(2), 0);
    drive(1, 1, 32'h2222, 0);
    drive(0, 0, 0, 1);
    chk("next_cmap", cycleMap, 32'h4);
    chk("next_ccount", cyclePacketCount, 1);

    drive(1, 0, h(7), 0);
    drive(1, 1, 32'h7777, 0);
    chk("pre_resync_code", statusCode, 0);
    drive(1, 0, h(7), 0);
    up = 0;
    step();
    chk("resync_tready", TREADY, 0);
    chk("resync_no_status", statusStrobe, 0);
    step();
    chk("resync_no_status2", statusStrobe, 0);
    chk("resync_hold_cmap", cycleMap, 32'h4);
    chk("resync_hold_err", errorCount, 4);
    up = 1;
    step();
    chk("resync_tready_up", TREADY, 1);
    drive(1, 0, h(7), 0);
    chk("resync_hdr_quiet", statusStrobe, 0);
    drive(1, 1, 32'h7707, 0);
    chk("resync_pstrobe", packetStrobe, 1);
    chk("resync_code", statusCode, 0);
    chk("resync_data", packetData, 32'h7707);
    chk("resync_err", errorCount, 4);

    drive(1, 0, h(1), 0);
    #2 rst_n = 0;
    #1 chk("async_reset", all_out(), 0);
    @(posedge clk);
    #1 rst_n = 1;
    step();
    chk("post_reset_tready", TREADY, 1);

    foreach (seen[b]) seen[b] = 0;
    cnt_m = 0;
    err_m = 0;
    mon_en = 1;
    for (int p = 0; p < 150; p++) begin
      pk.delete();
      hdr = $urandom;
      hdr[31:16] = 16'hB6CF;
      ix = $urandom_range(0, 11);
      hdr[14:10] = ix[4:0];
      k = $urandom_range(0, 9);
      s.idx = 0;
      s.data = 0;
      if (k == 0) begin
        hdr[31:16] = 16'hDEAD ^ 16'($urandom_range(0, 255));
        len = $urandom_range(1, 3);
        s.code = 1;
        err_m++;
      end else if (k <= 2) begin
        len = k == 1 ? 1 : $urandom_range(3, 4);
        s.code = 2;
        err_m++;
      end else begin
        len = 2;
        s.idx = ix[4:0];
        s.data = $urandom;
        s.code = seen[ix] ? 3 : 0;
        if (seen[ix]) err_m++;
        else begin
          seen[ix] = 1;
          cnt_m++;
        end
      end
      s.ec = 16'(err_m);
      sq.push_back(s);
      pk.push_back(hdr);
      for (int w = 1; w < len; w++) pk.push_back(w == 1 && k > 2 ? s.data : $urandom);
      send_pkt();
      if ($urandom_range(0, 4) == 0) begin
        for (int b = 0; b < 32; b++) m[b] = seen[b];
        c.map = m;
        c.cnt = 6'(cnt_m);
        cq.push_back(c);
        foreach (seen[b]) seen[b] = 0;
        cnt_m = 0;
        drive(0, 0, 0, 1);
      end
    end
    repeat (3) step();
    mon_en = 0;
    chk("status_drained", sq.size(), 0);
    chk("cycle_drained", cq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
